// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline hazard unit for the 5-stage Osiris core.
// Generates EX forwarding selects, load-use stalls, branch flushes, and
// sequences a fixed-latency multi-cycle MUL/DIV unit (MDU) held in EX.
// Optional feature macro: HAZARD_UNIT_MC_PERF_CNT_EN (saturating stall counter).
module hazard_unit_mc #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MDU_LATENCY    = 4,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1Addr_ID,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2Addr_ID,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1Addr_EX,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2Addr_EX,
    input  logic [REG_ADDR_WIDTH-1:0] i_rdAddr_EX,
    input  logic [1:0]                i_result_src_EX,
    input  logic                      i_pcSrc_EX,
    input  logic                      i_mdu_start_EX,
    input  logic [REG_ADDR_WIDTH-1:0] i_rdAddr_M,
    input  logic                      i_reg_write_M,
    input  logic [REG_ADDR_WIDTH-1:0] i_rdAddr_WB,
    input  logic                      i_reg_write_WB,
    output logic                      o_stall_IF,
    output logic                      o_stall_ID,
    output logic                      o_stall_EX,
    output logic                      o_flush_ID,
    output logic                      o_flush_EX,
    output logic                      o_flush_M,
    output logic [1:0]                o_forward_rs1_EX,
    output logic [1:0]                o_forward_rs2_EX,
    output logic                      o_mdu_busy,
    output logic                      o_mdu_done,
    output logic [CNT_WIDTH-1:0]      o_stall_cnt
);

    localparam int unsigned MDU_CNT_W = 8;
    localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LATENCY - 2);

    // Latency must fit the 8-bit down-counter and leave room for the DONE cycle
    if (MDU_LATENCY < 2 || MDU_LATENCY > 255) begin : g_cfg_err
        $error("hazard_unit_mc: MDU_LATENCY=%0d outside legal range 2..255", MDU_LATENCY);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    mdu_state_t           r_state;
    mdu_state_t           w_state_nxt;
    logic [MDU_CNT_W-1:0] r_cnt;
    logic [MDU_CNT_W-1:0] w_cnt_nxt;
    logic                 w_mdu_stall;
    logic                 w_load_use;
    logic [1:0]           w_fwd_rs1;
    logic [1:0]           w_fwd_rs2;

    // MDU sequencer state and latency counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MDU next-state; start is ignored in DONE since the same op is still in EX
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (i_mdu_start_EX) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = MDU_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - MDU_CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Forwarding selects: M result has priority over WB; x0 never forwards
    always_comb begin
        w_fwd_rs1 = 2'b00;
        w_fwd_rs2 = 2'b00;
        if (i_rs1Addr_EX != '0 && i_reg_write_M && i_rs1Addr_EX == i_rdAddr_M) begin
            w_fwd_rs1 = 2'b10;
        end else if (i_rs1Addr_EX != '0 && i_reg_write_WB && i_rs1Addr_EX == i_rdAddr_WB) begin
            w_fwd_rs1 = 2'b01;
        end
        if (i_rs2Addr_EX != '0 && i_reg_write_M && i_rs2Addr_EX == i_rdAddr_M) begin
            w_fwd_rs2 = 2'b10;
        end else if (i_rs2Addr_EX != '0 && i_reg_write_WB && i_rs2Addr_EX == i_rdAddr_WB) begin
            w_fwd_rs2 = 2'b01;
        end
    end

    // Hazard conditions: load-use needs a load (result_src 01) to a non-x0 rd
    always_comb begin
        w_load_use  = (i_result_src_EX == 2'b01) && (i_rdAddr_EX != '0) &&
                      ((i_rs1Addr_ID == i_rdAddr_EX) || (i_rs2Addr_ID == i_rdAddr_EX));
        w_mdu_stall = ((r_state == S_IDLE) && i_mdu_start_EX) || (r_state == S_BUSY);
    end

    // Prioritised pipeline controls; everything forced low while reset is held
    always_comb begin
        o_stall_IF       = 1'b0;
        o_stall_ID       = 1'b0;
        o_stall_EX       = 1'b0;
        o_flush_ID       = 1'b0;
        o_flush_EX       = 1'b0;
        o_flush_M        = 1'b0;
        o_forward_rs1_EX = 2'b00;
        o_forward_rs2_EX = 2'b00;
        o_mdu_busy       = 1'b0;
        o_mdu_done       = 1'b0;
        if (i_rst_n) begin
            o_forward_rs1_EX = w_fwd_rs1;
            o_forward_rs2_EX = w_fwd_rs2;
            o_mdu_busy       = (r_state != S_IDLE);
            o_mdu_done       = (r_state == S_DONE);
            if (w_mdu_stall) begin
                o_stall_IF = 1'b1;
                o_stall_ID = 1'b1;
                o_stall_EX = 1'b1;
                o_flush_M  = 1'b1;
            end else if (i_pcSrc_EX) begin
                o_flush_ID = 1'b1;
                o_flush_EX = 1'b1;
            end else if (w_load_use) begin
                o_stall_IF = 1'b1;
                o_stall_ID = 1'b1;
                o_flush_EX = 1'b1;
            end
        end
    end

`ifdef HAZARD_UNIT_MC_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Saturating count of front-end stall cycles; cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (o_stall_IF && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (MDU_LATENCY=4, CNT_WIDTH=4).
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_m, rd_wb;
    logic [1:0] res_src;
    logic       pcsrc, start, rw_m, rw_wb;
    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_m;
    logic [1:0] fwd1, fwd2;
    logic       busy, done;
    logic [3:0] scnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_ADDR_WIDTH(5),
        .MDU_LATENCY   (4),
        .CNT_WIDTH     (4)
    ) u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rs1Addr_ID    (rs1_id),
        .i_rs2Addr_ID    (rs2_id),
        .i_rs1Addr_EX    (rs1_ex),
        .i_rs2Addr_EX    (rs2_ex),
        .i_rdAddr_EX     (rd_ex),
        .i_result_src_EX (res_src),
        .i_pcSrc_EX      (pcsrc),
        .i_mdu_start_EX  (start),
        .i_rdAddr_M      (rd_m),
        .i_reg_write_M   (rw_m),
        .i_rdAddr_WB     (rd_wb),
        .i_reg_write_WB  (rw_wb),
        .o_stall_IF      (stall_if),
        .o_stall_ID      (stall_id),
        .o_stall_EX      (stall_ex),
        .o_flush_ID      (flush_id),
        .o_flush_EX      (flush_ex),
        .o_flush_M       (flush_m),
        .o_forward_rs1_EX(fwd1),
        .o_forward_rs2_EX(fwd2),
        .o_mdu_busy      (busy),
        .o_mdu_done      (done),
        .o_stall_cnt     (scnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
        rd_m = '0; rd_wb = '0; res_src = 2'b00; pcsrc = 1'b0; start = 1'b0;
        rw_m = 1'b0; rw_wb = 1'b0;
    endtask

    // Control outputs packed for compact comparison: {sIF,sID,sEX,fID,fEX,fM}
    function automatic logic [31:0] ctl();
        return {26'd0, stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_m};
    endfunction

    task automatic set_load_use();
        res_src = 2'b01; rd_ex = 5'd7; rs2_id = 5'd7; rs1_id = 5'd3;
    endtask

    int unsigned exp5, exp20;

    initial begin
`ifdef HAZARD_UNIT_MC_PERF_CNT_EN
        exp5 = 5; exp20 = 15;
`else
        exp5 = 0; exp20 = 0;
`endif
        clear_inputs();
        rst_n = 1'b0;
        // Reset held with hazard-provoking inputs: every control stays low
        rs1_ex = 5'd5; rd_m = 5'd5; rw_m = 1'b1; start = 1'b1; pcsrc = 1'b1;
        #3;
        check("rst_fwd1", 32'(fwd1), 32'd0);
        check("rst_ctl", ctl(), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(scnt), 32'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        check("idle_ctl", ctl(), 32'd0);

        // Forwarding priority and x0 suppression
        rs1_ex = 5'd5; rd_m = 5'd5; rw_m = 1'b1; rd_wb = 5'd5; rw_wb = 1'b1;
        #1; check("fwd_m", 32'(fwd1), 32'd2);
        rw_m = 1'b0;
        #1; check("fwd_wb", 32'(fwd1), 32'd1);
        rs1_ex = 5'd0; rd_m = 5'd0; rw_m = 1'b1; rd_wb = 5'd0;
        #1; check("fwd_x0", 32'(fwd1), 32'd0);
        rs2_ex = 5'd9; rd_m = 5'd3; rd_wb = 5'd9;
        #1; check("fwd2_wb", 32'(fwd2), 32'd1);
        clear_inputs();

        // Load-use only for result_src 01
        set_load_use();
        #1; check("lu_ctl", ctl(), 32'b110010);
        res_src = 2'b10;
        #1; check("lu_src10", ctl(), 32'b000000);
        clear_inputs();
        pcsrc = 1'b1;
        #1; check("br_ctl", ctl(), 32'b000110);
        clear_inputs();
        tick();

        // MDU op from cycle t with start held; done at t+4
        start = 1'b1;
        #1; check("mdu_t0_ctl", ctl(), 32'b111001);
        check("mdu_t0_busy", 32'(busy), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("mdu_t%0d_stall", i), 32'(stall_ex), 32'd1);
            check($sformatf("mdu_t%0d_done", i), 32'(done), 32'd0);
        end
        tick();
        check("mdu_t4_stall", 32'(stall_ex), 32'd0);
        check("mdu_t4_done", 32'(done), 32'd1);
        check("mdu_t4_busy", 32'(busy), 32'd1);
        // Back-to-back op at t+5 starts a fresh sequence
        tick();
        check("b2b_t5_busy", 32'(busy), 32'd0);
        check("b2b_t5_done", 32'(done), 32'd0);
        check("b2b_t5_stall", 32'(stall_ex), 32'd1);
        tick();
        // BUSY outranks branch and load-use
        pcsrc = 1'b1; set_load_use();
        #1; check("prio_busy_ctl", ctl(), 32'b111001);
        tick();
        check("b2b_t7_stall", 32'(stall_ex), 32'd1);
        tick();
        check("b2b_t8_stall", 32'(stall_ex), 32'd1);
        tick();
        clear_inputs(); start = 1'b1; pcsrc = 1'b1;
        #1; check("prio_done_done", 32'(done), 32'd1);
        check("prio_done_ctl", ctl(), 32'b000110);
        tick();
        clear_inputs();
        #1; check("after_busy", 32'(busy), 32'd0);

        // Reset asserted at t+2 of an MDU op aborts it
        start = 1'b1;
        tick();
        tick();
        rs1_ex = 5'd4; rd_m = 5'd4; rw_m = 1'b1;
        rst_n = 1'b0;
        #1; check("rmid_ctl", ctl(), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_fwd", 32'(fwd1), 32'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        #1; check("rmid_rel_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rmid_nodone%0d", i), 32'(done), 32'd0);
        end
        check("perf_zero", 32'(scnt), 32'd0);

        // Stall counter: 5 stalled edges, then 20 total (saturates at 15)
        set_load_use();
        for (int i = 0; i < 5; i++) tick();
        check("perf_5", 32'(scnt), exp5);
        for (int i = 0; i < 15; i++) tick();
        check("perf_20", 32'(scnt), exp20);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
